max_pool_stream: RTL and testbench
==================================

MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning unsigned pixel width in bits (range 1..16).
REQ-002 The block SHALL have parameter IMG_W, default 28, meaning input columns per row (even, at least 2).
REQ-003 The block SHALL have parameter IMG_H, default 28, meaning input rows per frame (even, at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-007 The block SHALL have port mode, input, 1 bit: pooling mode, 0 = max and 1 = average; sampled only at frame start.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the input pixel is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a pixel.
REQ-010 The block SHALL have port in_data, input, DATA_W bits: the pixel, in raster order (row-major, column 0 first).
REQ-011 The block SHALL have port out_valid, output, 1 bit: a pooled result is held.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: the pooled value.
REQ-014 The block SHALL have port out_last, output, 1 bit: marks the final pooled value of the frame.

Function
REQ-015 A pixel SHALL be accepted only in a cycle where in_valid and in_ready are both 1; an output SHALL be consumed only in a cycle where out_valid and out_ready are both 1.
REQ-016 The block SHALL implement a 2x2 window with stride 2, producing (IMG_W/2)*(IMG_H/2) outputs per frame in raster order.
REQ-017 The block SHALL track each accepted pixel's position with a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), both wrapping to 0 after the last pixel of the frame.
REQ-018 In an even row, the block SHALL hold the even-column pixel in a pair register and write the pair result, combined with the odd-column pixel, into line-buffer entry col/2 (IMG_W/2 entries).
REQ-019 In max mode, the pair result SHALL be the unsigned maximum of the two pixels; in average mode it SHALL be their (DATA_W+1)-bit sum.
REQ-020 In an odd row, on acceptance of an odd-column pixel, the block SHALL combine the pair result with line-buffer entry col/2 and load the output register.
REQ-021 Average-mode output SHALL be the (DATA_W+2)-bit four-pixel sum shifted right by 2, truncated toward zero with no rounding; max mode SHALL never overflow.
REQ-022 Latency SHALL be 1 cycle: out_valid rises in the cycle after the completing pixel is accepted.
REQ-023 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 in_ready SHALL equal (not out_valid) or out_ready, and SHALL be independent of in_valid.
REQ-025 A simultaneous output consume and new-result load in the same cycle SHALL keep out_valid=1 with the new data, dropping no data.
REQ-026 out_last SHALL be 1 exactly with the result from row IMG_H-1, column IMG_W-1.
REQ-027 When clear=1, the counters, pair register, and out_valid SHALL return to 0 in the next cycle and any pixel offered that cycle SHALL be discarded; clear SHALL take priority over acceptance.
REQ-028 mode SHALL be latched when a pixel is accepted at row 0, column 0; mid-frame changes SHALL have no effect until the next frame.

Reset
REQ-029 While rst_n=0, the block SHALL set out_valid=0, out_data=0, out_last=0, all counters 0, the pair register 0, and latched mode 0 (max), with in_ready=1 since out_valid=0.
REQ-030 Line-buffer contents SHALL need no reset, because every entry is written in an even row before it is read.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the first pixel accepted after release SHALL be treated as row 0, column 0.

Structure
REQ-032 A shared package SHALL hold the mode encodings (MODE_MAX=0, MODE_AVG=1) and the default DATA_W, IMG_W, and IMG_H constants.
REQ-033 The pair/window combine logic SHALL be one sub-module, pool_combine (inputs a, b, mode; output max or sum), instantiated for both the horizontal and vertical stages.

Verification
REQ-034 4x4 frame, DATA_W=8, max mode, pixels 0..15 in raster order with out_ready=1 -> outputs 5, 7, 13, 15; out_last only on 15.
REQ-035 Same frame, average mode -> outputs 2, 4, 10, 12 (for example, (0+1+4+5)>>2 = 2).
REQ-036 All pixels 255 in average mode -> every output is 255, showing no sum overflow.
REQ-037 out_ready held at 0 after the first result -> in_ready=0, out_data stays 5, no pixel is lost, and the stream resumes correctly on release.
REQ-038 clear pulsed after 6 pixels, then a full frame of 0..15 -> outputs 5, 7, 13, 15 with no stale line-buffer data.
REQ-039 rst_n asserted mid-frame -> all outputs 0 immediately; the next frame pools correctly and mode is changed only at the frame boundary.

Source files
------------

// File: rtl/max_pool_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_stream_pkg
// Description : Shared mode encodings and default geometry for the 2x2
//               streaming pooling block.
// Revision    : 1.0 - initial release
// ============================================================================
package max_pool_stream_pkg;

  // Pooling mode, sampled at the first pixel of each frame
  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } mode_e;

  localparam int C_DATA_W = 8;
  localparam int C_IMG_W  = 28;
  localparam int C_IMG_H  = 28;

endpackage
`default_nettype wire

// File: rtl/max_pool_stream_combine.sv
`default_nettype none
// ============================================================================
// Module      : pool_combine
// Description : Pairwise combine used by both pooling stages. Max mode gives
//               the zero-extended unsigned maximum; average mode gives the
//               full-width sum so later stages never overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_combine
  import max_pool_stream_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  input  mode_e           mode,
  output logic [IN_W:0]   y
);

  logic [IN_W:0] w_sum;
  logic [IN_W:0] w_max;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_max = (a > b) ? {1'b0, a} : {1'b0, b};

  // Select the mode-dependent combine result
  always_comb begin
    y = w_max;
    if (mode == MODE_AVG) begin
      y = w_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/max_pool_stream.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_stream
// Description : Streaming 2x2 / stride-2 max or average pooling over a
//               raster-ordered frame, with a half-row line buffer holding
//               the horizontal pair results of each even row.
// Revision    : 1.0 - initial release
// ============================================================================
module max_pool_stream
  import max_pool_stream_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int IMG_W  = C_IMG_W,
  parameter int IMG_H  = C_IMG_H
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_N  = IMG_W / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_pair;
  mode_e             r_mode;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [DATA_W:0]   r_lbuf [LB_N];

  logic              w_in_ready;
  logic              w_accept;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_first;
  logic              w_even_row;
  logic              w_odd_col;
  logic              w_load;
  logic [LB_AW-1:0]  w_lb_idx;
  logic [DATA_W:0]   w_lb_rd;
  logic [DATA_W:0]   w_hres;
  logic [DATA_W+1:0] w_vres;
  logic [DATA_W-1:0] w_out_val;

  // A pending result blocks input only when downstream is not taking it
  assign w_in_ready = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & w_in_ready & ~clear;
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_first    = (r_col == '0) && (r_row == '0);
  assign w_even_row = ~r_row[0];
  assign w_odd_col  = r_col[0];
  assign w_load     = w_accept & ~w_even_row & w_odd_col;
  assign w_lb_idx   = LB_AW'(r_col >> 1);
  assign w_lb_rd    = r_lbuf[w_lb_idx];

  pool_combine #(
    .IN_W (DATA_W)
  ) u_horiz (
    .a    (r_pair),
    .b    (in_data),
    .mode (r_mode),
    .y    (w_hres)
  );

  pool_combine #(
    .IN_W (DATA_W + 1)
  ) u_vert (
    .a    (w_lb_rd),
    .b    (w_hres),
    .mode (r_mode),
    .y    (w_vres)
  );

  // Reduce the four-pixel window to an output pixel (sum/4 truncates)
  always_comb begin
    w_out_val = w_vres[DATA_W-1:0];
    if (r_mode == MODE_AVG) begin
      w_out_val = w_vres[DATA_W+1:2];
    end
  end

  // Raster position counters; clear wins over acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Even-column pixel held for pairing in every row; mode latched per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair <= '0;
      r_mode <= MODE_MAX;
    end else if (clear) begin
      r_pair <= '0;
    end else if (w_accept) begin
      if (!w_odd_col) begin
        r_pair <= in_data;
      end
      if (w_first) begin
        r_mode <= mode_e'(mode);
      end
    end
  end

  // Line buffer: written on every even row before the odd row reads it
  always_ff @(posedge clk) begin
    if (w_accept && w_even_row && w_odd_col) begin
      r_lbuf[w_lb_idx] <= w_hres;
    end
  end

  // Output register; a load in a consume cycle keeps valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_out_val;
      r_out_last  <= w_row_last & w_col_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_pool_stream
// Description : Self-checking bench for max_pool_stream on a 4x4 frame with
//               a frame-level reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_stream;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;

  max_pool_stream #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int d;
    bit l;
  } exp_t;

  exp_t q[$];
  int   pix[H][W];
  int   mr = 0;
  int   mc = 0;
  bit   mmode = 1'b0;
  int   cap[$];
  bit   capl[$];
  int   ready_sel = 1;   // 0: hold low, 1: hold high, 2: random
  int   gap_max = 0;
  bit   rand_mode = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_sel)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model and per-cycle comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      q.delete();
      mr = 0;
      mc = 0;
    end else begin
      chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_data", int'(out_data), q[0].d);
        chk("out_last", int'(out_last), int'(q[0].l));
      end
      if (out_valid && out_ready) begin
        cap.push_back(int'(out_data));
        capl.push_back(out_last);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (clear) begin
        q.delete();
        mr = 0;
        mc = 0;
      end else if (in_valid && in_ready) begin
        if (mr == 0 && mc == 0) mmode = mode;
        pix[mr][mc] = int'(in_data);
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
          exp_t e;
          int a, b, c, d, m;
          a = pix[mr-1][mc-1];
          b = pix[mr-1][mc];
          c = pix[mr][mc-1];
          d = pix[mr][mc];
          if (mmode) begin
            e.d = (a + b + c + d) / 4;
          end else begin
            m = a;
            if (b > m) m = b;
            if (c > m) m = c;
            if (d > m) m = d;
            e.d = m;
          end
          e.l = (mr == H - 1) && (mc == W - 1);
          q.push_back(e);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end
      end
    end
  end

  task automatic push(input int px);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(px);
    if (rand_mode) mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      #1;
    end
  endtask

  // kind 0: ramp 0..15, 1: all 255, 2: random
  task automatic send_frame(input int kind);
    for (int i = 0; i < W * H; i++) begin
      if (kind == 0) push(i);
      else if (kind == 1) push(255);
      else push(int'($urandom_range(0, 255)));
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_cap(input string name, input int e0, input int e1,
                           input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, cap.size(), 4);
    if (cap.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk({name, "_value"}, cap[i], e[i]);
        chk({name, "_last"}, int'(capl[i]), int'(i == 3));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Max mode ramp frame
    ready_sel = 1;
    mode = 1'b0;
    cap.delete(); capl.delete();
    send_frame(0);
    drain();
    check_cap("max_ramp", 5, 7, 13, 15);

    // Average mode ramp frame
    mode = 1'b1;
    cap.delete(); capl.delete();
    send_frame(0);
    drain();
    check_cap("avg_ramp", 2, 4, 10, 12);

    // Average of saturated pixels
    cap.delete(); capl.delete();
    send_frame(1);
    drain();
    check_cap("avg_255", 255, 255, 255, 255);

    // Backpressure after the first result
    mode = 1'b0;
    ready_sel = 0;
    cap.delete(); capl.delete();
    for (int i = 0; i < 6; i++) push(i);
    in_valid = 1'b1;
    in_data  = 8'd6;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_data", int'(out_data), 5);
    end
    ready_sel = 2;
    for (int i = 6; i < 16; i++) push(i);
    drain();
    check_cap("backpressure", 5, 7, 13, 15);

    // Abort after six pixels, then a clean frame
    ready_sel = 1;
    for (int i = 0; i < 6; i++) push(i + 100);
    do_clear();
    cap.delete(); capl.delete();
    send_frame(0);
    drain();
    check_cap("after_clear", 5, 7, 13, 15);

    // Reset mid-frame; next frame latches mode only at its first pixel
    mode = 1'b1;
    for (int i = 0; i < 7; i++) push(i + 50);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_data", int'(out_data), 0);
    chk("async_rst_last", int'(out_last), 0);
    chk("async_rst_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 1'b0;
    cap.delete(); capl.delete();
    for (int i = 0; i < 16; i++) begin
      push(i);
      if (i == 0) mode = 1'b1;
    end
    drain();
    check_cap("after_reset", 5, 7, 13, 15);

    // Randomized frames with gaps, backpressure, mode noise and aborts
    ready_sel = 2;
    gap_max = 2;
    rand_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < W * H; i++) begin
        push(int'($urandom_range(0, 255)));
        if ($urandom_range(0, 39) == 0) do_clear();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
